// File: rtl/case_decoder_pipe.sv
// case_decoder_pipe
//   Decodes a stream of binary codes into one-hot words through a 2-entry
//   output FIFO. Each stored word carries a repeat tag that is set when its
//   code equals the previously accepted code. A saturating counter tracks
//   how many words have been delivered downstream.
//
// Ports
//   clk           rising-edge clock for all state
//   rst_n         asynchronous active-low reset
//   in_valid      upstream code valid
//   in_ready      a code can be accepted this cycle (occupancy < 2)
//   in            binary code, IN_W bits
//   out_valid     head of buffer holds a word
//   out_ready     downstream accepts the head word this cycle
//   onehot_out    one-hot decode of the head code (zero when empty)
//   repeat_flag   head code repeats the code accepted just before it
//   decode_count  delivered-word count, saturating at all ones
module case_decoder_pipe #(
  parameter  int IN_W  = 2,
  parameter  int CNT_W = 8,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] onehot_out,
  output logic             repeat_flag,
  output logic [CNT_W-1:0] decode_count
);

  logic [OUT_W-1:0] word_q [2];
  logic             rpt_q  [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;
  logic [IN_W-1:0]  last_code;
  logic             last_vld;
  logic [CNT_W-1:0] count_q;

  logic [OUT_W-1:0] dec;
  logic             rpt_new;
  logic             push;
  logic             pop;

  // Full decode: every code value selects its own distinct output bit.
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (in == IN_W'(i)) dec[i] = 1'b1;
    end
  end

  assign rpt_new   = last_vld && (in == last_code);

  // Readiness comes from registered occupancy only, never from out_ready.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign onehot_out   = out_valid ? word_q[rd_ptr] : '0;
  assign repeat_flag  = out_valid ? rpt_q[rd_ptr]  : 1'b0;
  assign decode_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        word_q[i] <= '0;
        rpt_q[i]  <= 1'b0;
      end
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      occ       <= 2'd0;
      last_code <= '0;
      last_vld  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= dec;
        rpt_q[wr_ptr]  <= rpt_new;
        wr_ptr         <= ~wr_ptr;
        last_code      <= in;
        last_vld       <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (count_q != '1) count_q <= count_q + 1'b1;
      end
      // With one entry, push+pop writes the slot rd_ptr advances onto,
      // so the new word becomes head while occupancy stays at one.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_case_decoder_pipe.sv
module tb_case_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] code = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] onehot_out;
  logic       repeat_flag;
  logic [7:0] decode_count;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [1:0] s_code = '0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic [3:0] s_onehot_out;
  logic       s_repeat_flag;
  logic [1:0] s_decode_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  case_decoder_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(code),
    .out_valid(out_valid), .out_ready(out_ready),
    .onehot_out(onehot_out), .repeat_flag(repeat_flag),
    .decode_count(decode_count)
  );

  case_decoder_pipe #(.IN_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in(s_code),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .onehot_out(s_onehot_out), .repeat_flag(s_repeat_flag),
    .decode_count(s_decode_count)
  );

  // Advance one rising edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; code = 2'b11; out_ready = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, onehot_out, repeat_flag, decode_count} !== {1'b1, 1'b0, 4'b0000, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b oh=%b rpt=%b cnt=%0d exp rdy=1 vld=0 oh=0000 rpt=0 cnt=0",
               in_ready, out_valid, onehot_out, repeat_flag, decode_count);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; code = 2'b10; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, onehot_out, repeat_flag, decode_count} !== {1'b1, 4'b0100, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL single_head got vld=%b oh=%b rpt=%b cnt=%0d exp vld=1 oh=0100 rpt=0 cnt=0",
               out_valid, onehot_out, repeat_flag, decode_count);
    end
    step();
    checks++;
    if ({out_valid, onehot_out, decode_count} !== {1'b0, 4'b0000, 8'd1}) begin
      errors++;
      $display("FAIL single_pop got vld=%b oh=%b cnt=%0d exp vld=0 oh=0000 cnt=1",
               out_valid, onehot_out, decode_count);
    end
    // Empty: out_ready high must not bump the counter.
    step();
    checks++;
    if ({out_valid, decode_count} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL empty_pop got vld=%b cnt=%0d exp vld=0 cnt=1", out_valid, decode_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_all_codes();
    logic [3:0] exp_oh [4];
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100; exp_oh[3] = 4'b1000;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = 2'(i);
      step();
      checks++;
      if ({out_valid, onehot_out, repeat_flag} !== {1'b1, exp_oh[i], 1'b0}) begin
        errors++;
        $display("FAIL decode_%0d got vld=%b oh=%b rpt=%b exp vld=1 oh=%b rpt=0",
                 i, out_valid, onehot_out, repeat_flag, exp_oh[i]);
      end
    end
    code = 2'b11;
    step();
    checks++;
    if ({onehot_out, repeat_flag, decode_count} !== {4'b1000, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL decode_repeat got oh=%b rpt=%b cnt=%0d exp oh=1000 rpt=1 cnt=4",
               onehot_out, repeat_flag, decode_count);
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; code = 2'b01;
    step();
    checks++;
    if ({in_ready, out_valid, onehot_out, repeat_flag} !== {1'b1, 1'b1, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL b2b_push1 got rdy=%b vld=%b oh=%b rpt=%b exp rdy=1 vld=1 oh=0010 rpt=0",
               in_ready, out_valid, onehot_out, repeat_flag);
    end
    step();
    checks++;
    if ({in_ready, onehot_out, repeat_flag} !== {1'b0, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL b2b_full got rdy=%b oh=%b rpt=%b exp rdy=0 oh=0010 rpt=0",
               in_ready, onehot_out, repeat_flag);
    end
    code = 2'b11;
    step();
    checks++;
    if ({in_ready, onehot_out, repeat_flag, decode_count} !== {1'b0, 4'b0010, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL b2b_hold got rdy=%b oh=%b rpt=%b cnt=%0d exp rdy=0 oh=0010 rpt=0 cnt=0",
               in_ready, onehot_out, repeat_flag, decode_count);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_indep got rdy=%b exp rdy=0", in_ready);
    end
    step();
    checks++;
    if ({in_ready, onehot_out, repeat_flag, decode_count} !== {1'b1, 4'b0010, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL drain1 got rdy=%b oh=%b rpt=%b cnt=%0d exp rdy=1 oh=0010 rpt=1 cnt=1",
               in_ready, onehot_out, repeat_flag, decode_count);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, onehot_out, repeat_flag, decode_count} !== {1'b1, 4'b1000, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL drain2 got vld=%b oh=%b rpt=%b cnt=%0d exp vld=1 oh=1000 rpt=0 cnt=2",
               out_valid, onehot_out, repeat_flag, decode_count);
    end
    step();
    checks++;
    if ({out_valid, onehot_out, repeat_flag, decode_count} !== {1'b0, 4'b0000, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL drain3 got vld=%b oh=%b rpt=%b cnt=%0d exp vld=0 oh=0000 rpt=0 cnt=3",
               out_valid, onehot_out, repeat_flag, decode_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [6];
    exp_cnt[0] = 2'd0; exp_cnt[1] = 2'd1; exp_cnt[2] = 2'd2;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3; exp_cnt[5] = 2'd3;
    do_reset();
    s_in_valid = 1'b1; s_code = 2'b00; s_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_decode_count !== exp_cnt[i]) begin
        errors++;
        $display("FAIL sat_count_%0d got %0d exp %0d", i, s_decode_count, exp_cnt[i]);
      end
    end
    s_in_valid = 1'b0; s_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    code = 2'b11;
    step();
    code = 2'b10;
    step();
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_prefull got rdy=%b vld=%b exp rdy=0 vld=1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, onehot_out, repeat_flag} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL mid_async got rdy=%b vld=%b oh=%b rpt=%b exp rdy=1 vld=0 oh=0000 rpt=0",
               in_ready, out_valid, onehot_out, repeat_flag);
    end
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; code = 2'b10;
    step();
    checks++;
    if ({out_valid, onehot_out, repeat_flag} !== {1'b1, 4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL mid_no_repeat got vld=%b oh=%b rpt=%b exp vld=1 oh=0100 rpt=0",
               out_valid, onehot_out, repeat_flag);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, onehot_out, repeat_flag, decode_count} !== {1'b1, 4'b0100, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL mid_repeat got vld=%b oh=%b rpt=%b cnt=%0d exp vld=1 oh=0100 rpt=1 cnt=1",
               out_valid, onehot_out, repeat_flag, decode_count);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_all_codes();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
